// File: rtl/mag_cmp_arbiter.sv
// Round-robin arbiter that time-shares one W-bit magnitude comparator among NREQ requesters.
// Define MAG_CMP_SIGNED_EN to compare operands as two's-complement instead of unsigned.
module mag_cmp_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] a_in,
    input  logic [NREQ*W-1:0] b_in,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic              Ya,
    output logic              Yb,
    output logic              Ye,
    output logic              busy
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Returns {a>b, a<b, a==b}; exactly one bit is set.
    function automatic logic [2:0] cmp_flags(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MAG_CMP_SIGNED_EN
        logic signed [W-1:0] sa;
        logic signed [W-1:0] sb;
        sa = $signed(a);
        sb = $signed(b);
        return {sa > sb, sa < sb, sa == sb};
`else
        return {a > b, a < b, a == b};
`endif
    endfunction

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [IW-1:0]     cur_q, cur_d;
    logic [W-1:0]      opa_q, opa_d;
    logic [W-1:0]      opb_q, opb_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [NREQ-1:0]   done_q, done_d;
    logic [2:0]        flags_q, flags_d;
    logic              busy_q, busy_d;
    logic              found;
    int                win;

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cur_d   = cur_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        gnt_d   = '0;
        done_d  = '0;
        flags_d = flags_q;
        found   = 1'b0;
        win     = 0;

        // Round-robin search starting at ptr, wrapping modulo NREQ.
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req[(int'(ptr_q) + i) % NREQ]) begin
                found = 1'b1;
                win   = (int'(ptr_q) + i) % NREQ;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    cur_d      = IW'(win);
                    opa_d      = a_in[win*W +: W];
                    opb_d      = b_in[win*W +: W];
                    gnt_d[win] = 1'b1;
                    state_d    = CMP;
                end
            end
            CMP: begin
                flags_d       = cmp_flags(opa_q, opb_q);
                done_d[cur_q] = 1'b1;
                state_d       = RESP;
            end
            RESP: begin
                ptr_d   = (cur_q == IW'(NREQ - 1)) ? '0 : cur_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            cur_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            flags_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cur_q   <= cur_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            flags_q <= flags_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign Ya   = flags_q[2];
    assign Yb   = flags_q[1];
    assign Ye   = flags_q[0];
    assign busy = busy_q;

endmodule

// File: tb/tb_mag_cmp_arbiter.sv
// Scoreboard bench for mag_cmp_arbiter: stimulus queues expected grants/results, a monitor checks them.
module tb_mag_cmp_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 3;
    localparam logic [2:0] GT = 3'b100;
    localparam logic [2:0] LT = 3'b010;
    localparam logic [2:0] EQ = 3'b001;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] a_in;
    logic [NREQ*W-1:0] b_in;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              Ya, Yb, Ye, busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [3:0] exp_gnt[$];
    logic [6:0] exp_done[$];

    mag_cmp_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .done(done), .Ya(Ya), .Yb(Yb), .Ye(Ye), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic logic [2:0] ref_flags(int a, int b);
        int sa;
        int sb;
        sa = a;
        sb = b;
`ifdef MAG_CMP_SIGNED_EN
        if (sa > 3) sa = sa - 8;
        if (sb > 3) sb = sb - 8;
`endif
        return {sa > sb, sa < sb, sa == sb};
    endfunction

    // Monitor: pops expectations whenever the DUT presents a grant or result.
    int         last_gnt_cyc = -100;
    logic [3:0] prev_gnt  = '0;
    logic [3:0] prev_done = '0;
    always @(negedge clk) begin
        logic [3:0] eg;
        logic [6:0] ed;
        if (gnt != 0) begin
            if (exp_gnt.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_gnt: got %b expected none", gnt);
            end else begin
                eg = exp_gnt.pop_front();
                chk("gnt_onehot", int'(gnt), int'(eg));
            end
            last_gnt_cyc = cyc;
        end
        if (done != 0) begin
            if (exp_done.size() == 0) begin
                checks++; failures++;
                $display("FAIL unexpected_done: got %b expected none", done);
            end else begin
                ed = exp_done.pop_front();
                chk("done_onehot", int'(done), int'(ed[6:3]));
                chk("result_flags", int'({Ya, Yb, Ye}), int'(ed[2:0]));
                chk("done_latency", cyc - last_gnt_cyc, 1);
            end
        end
        if ((gnt | done) != 0) begin
            chk("gnt_done_overlap", int'(gnt & done), 0);
            chk("pulse_repeat", int'((gnt & prev_gnt) | (done & prev_done)), 0);
        end
        prev_gnt  = gnt;
        prev_done = done;
    end

    task automatic wait_gnt(input logic [3:0] mask);
        bit ok = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if ((gnt & mask) != 0) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL gnt_timeout: got none expected mask %b", mask);
        end
    endtask

    task automatic wait_done();
        bit ok = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done != 0) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL done_timeout: got none expected a done pulse");
        end
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (!busy) begin ok = 1; break; end
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL idle_timeout: busy=%0d expected 0", busy);
        end
    endtask

    task automatic single(input int i, input int a, input int b, input logic [2:0] fl);
        logic [3:0] oh;
        oh = 4'(1 << i);
        exp_gnt.push_back(oh);
        exp_done.push_back({oh, fl});
        a_in[i*W +: W] = 3'(a);
        b_in[i*W +: W] = 3'(b);
        req[i] = 1'b1;
        wait_gnt(oh);
        req[i] = 1'b0;
        wait_done();
    endtask

    int prev_cyc;

    initial begin
        rst  = 1'b1;
        req  = 4'b1111;
        a_in = '0;
        b_in = '0;
        @(posedge clk);
        repeat (2) begin
            @(negedge clk);
            chk("reset_outputs", int'({gnt, done, Ya, Yb, Ye, busy}), 0);
        end

        // Fairness: all four requesting with equal operands, then requester 1 drops out.
        foreach (exp_gnt[k]) exp_gnt.delete(k);
        begin
            logic [3:0] order[8];
            order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0100, 4'b1000, 4'b0001};
            for (int k = 0; k < 8; k++) begin
                exp_gnt.push_back(order[k]);
                exp_done.push_back({order[k], EQ});
            end
        end
        rst = 1'b0;
        prev_cyc = 0;
        for (int k = 0; k < 8; k++) begin
            wait_gnt(4'b1111);
            if (k > 0) chk("rr_spacing", cyc - prev_cyc, 3);
            prev_cyc = cyc;
            if (k == 4) req[1] = 1'b0;
            if (k == 7) req = 4'b0000;
        end
        wait_idle();

`ifdef MAG_CMP_SIGNED_EN
        single(0, 5, 3, LT);
        single(2, 6, 6, EQ);
        single(2, 1, 7, GT);
        single(0, 4, 3, LT);
`else
        single(0, 5, 3, GT);
        single(2, 6, 6, EQ);
        single(2, 1, 7, LT);
        single(0, 4, 3, GT);
`endif

        // Leave ptr at 2 and flags non-zero, then abort a transaction during CMP.
        single(1, 2, 1, GT);
        exp_gnt.push_back(4'b1000);
        a_in[3*W +: W] = 3'd0;
        b_in[3*W +: W] = 3'd0;
        req[3] = 1'b1;
        wait_gnt(4'b1000);
        rst = 1'b1;
        req = 4'b0000;
        @(negedge clk);
        chk("abort_outputs", int'({gnt, done, Ya, Yb, Ye, busy}), 0);
        rst = 1'b0;
        exp_gnt.push_back(4'b0001);
        exp_done.push_back({4'b0001, EQ});
        exp_gnt.push_back(4'b0100);
        exp_done.push_back({4'b0100, LT});
        a_in[0 +: W]   = 3'd3;
        b_in[0 +: W]   = 3'd3;
        a_in[2*W +: W] = 3'd0;
        b_in[2*W +: W] = 3'd1;
        req = 4'b0101;
        wait_gnt(4'b0001);
        req[0] = 1'b0;
        wait_gnt(4'b0100);
        req[2] = 1'b0;
        wait_idle();

        for (int a = 0; a < 8; a++)
            for (int b = 0; b < 8; b++)
                single(0, a, b, ref_flags(a, b));

        repeat (3) @(negedge clk);
        chk("sb_gnt_empty", exp_gnt.size(), 0);
        chk("sb_done_empty", exp_done.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
